// File: rtl/gpu_wb_slave_if_if.sv
// Wishbone B4 classic bus bundle between the SoC master and the GPU slave front-end.
//
// Handshake: a request is presented while wb_cyc_i and wb_stb_i are both high and
// is held stable by the master until the slave answers with a single-cycle
// wb_ack_o (done) or wb_err_o (unmapped address); never both. Dropping cyc or stb
// before the answer abandons the transfer without any response.
interface gpu_wb_slave_if_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [DATA_W/8-1:0]   wb_sel_i;
    logic [ADDR_W-1:0]     wb_adr_i;
    logic [DATA_W-1:0]     wb_dat_i;
    logic [DATA_W-1:0]     wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/gpu_wb_slave_if.sv
// Wishbone classic slave front-end for the GPU register/memory space.
// Decodes a region index from the address, issues one-hot write/read strobes to
// the backing memories, waits the configured write wait states or read latency,
// then acks. Unmapped regions get a single-cycle error and bump a saturating count.
module gpu_wb_slave_if #(
    parameter int ADDR_W       = 27,
    parameter int DATA_W       = 32,
    parameter int RSEL_W       = 4,
    parameter int REGION_LSB   = 12,
    parameter int N_REGION     = 3,
    parameter int READ_LATENCY = 1,
    parameter int WAIT_CYCLES  = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    gpu_wb_slave_if_if.slave           wb,
    output logic [N_REGION-1:0]        o_we,
    output logic [N_REGION-1:0]        o_re,
    output logic [ADDR_W-1:0]          o_addr,
    output logic [DATA_W-1:0]          o_wdata,
    output logic [DATA_W/8-1:0]        o_wsel,
    input  logic [N_REGION*DATA_W-1:0] i_rdata,
    output logic                       o_busy,
    output logic [7:0]                 o_err_count,
    output logic [2:0]                 o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WSTROBE = 3'd1,
        S_WWAIT   = 3'd2,
        S_RSTROBE = 3'd3,
        S_RWAIT   = 3'd4,
        S_ACK     = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    // Region count widened by one bit so N_REGION == 2^RSEL_W is representable.
    localparam logic [RSEL_W:0] N_REGION_W = (RSEL_W + 1)'(N_REGION);
    localparam logic [3:0]      LAST_WAIT  = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0]      LAST_RWAIT = 4'(READ_LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic [RSEL_W-1:0]     region_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wsel_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [7:0]            err_cnt_q;

    logic                  req;
    logic [RSEL_W-1:0]     req_region;
    logic                  req_mapped;
    logic [N_REGION-1:0]   region_oh;
    logic [DATA_W-1:0]     rd_slice;

    assign req        = wb.wb_cyc_i & wb.wb_stb_i;
    assign req_region = wb.wb_adr_i[REGION_LSB +: RSEL_W];
    assign req_mapped = ({1'b0, req_region} < N_REGION_W);

    // Decode the latched region into a one-hot strobe mask and select its read slice.
    always_comb begin
        region_oh = '0;
        rd_slice  = '0;
        for (int k = 0; k < N_REGION; k++) begin
            if (region_q == RSEL_W'(k)) begin
                region_oh[k] = 1'b1;
                rd_slice     = i_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; any non-IDLE state before ACK/ERR abandons on a master abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!req_mapped)         state_d = S_ERR;
                    else if (wb.wb_we_i)     state_d = S_WSTROBE;
                    else                     state_d = S_RSTROBE;
                end
            end
            S_WSTROBE: begin
                if (!req)                    state_d = S_IDLE;
                else if (WAIT_CYCLES == 0)   state_d = S_ACK;
                else                         state_d = S_WWAIT;
            end
            S_WWAIT: begin
                if (!req)                    state_d = S_IDLE;
                else if (cnt_q == LAST_WAIT) state_d = S_ACK;
            end
            S_RSTROBE: begin
                if (!req)                    state_d = S_IDLE;
                else                         state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (!req)                     state_d = S_IDLE;
                else if (cnt_q == LAST_RWAIT) state_d = S_ACK;
            end
            S_ACK:                           state_d = S_IDLE;
            S_ERR:                           state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Request capture, wait counter, read-data capture and error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            region_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wsel_q    <= '0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && req) begin
                addr_q   <= wb.wb_adr_i;
                wdata_q  <= wb.wb_dat_i;
                wsel_q   <= wb.wb_sel_i;
                region_q <= req_region;
                cnt_q    <= '0;
                if (!req_mapped && err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
            if (state_q == S_WWAIT || state_q == S_RWAIT) begin
                cnt_q <= cnt_q + 4'd1;
            end
            // Data is valid in the final RWAIT cycle; an aborted read never lands here.
            if (state_q == S_RWAIT && req && cnt_q == LAST_RWAIT) begin
                rdata_q <= rd_slice;
            end
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        o_we          = '0;
        o_re          = '0;
        wb.wb_ack_o   = 1'b0;
        wb.wb_err_o   = 1'b0;
        if (state_q == S_WSTROBE) o_we = region_oh;
        if (state_q == S_RSTROBE) o_re = region_oh;
        if (state_q == S_ACK)     wb.wb_ack_o = 1'b1;
        if (state_q == S_ERR)     wb.wb_err_o = 1'b1;
        o_busy        = (state_q != S_IDLE);
        o_state       = state_q;
        wb.wb_dat_o   = rdata_q;
        o_addr        = addr_q;
        o_wdata       = wdata_q;
        o_wsel        = wsel_q;
        o_err_count   = err_cnt_q;
    end

endmodule

// File: tb/tb_gpu_wb_slave_if.sv
// Bench for gpu_wb_slave_if: directed scenarios followed by randomized traffic,
// compared against a word-level memory/latency model of the slave.
module tb_gpu_wb_slave_if;

    localparam int AW   = 27;
    localparam int DW   = 32;
    localparam int NREG = 3;
    localparam int RL   = 2;
    localparam int WC   = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    gpu_wb_slave_if_if #(.ADDR_W(AW), .DATA_W(DW)) wb_bus ();

    logic [NREG-1:0]    o_we, o_re;
    logic [AW-1:0]      o_addr;
    logic [DW-1:0]      o_wdata;
    logic [3:0]         o_wsel;
    logic [NREG*DW-1:0] i_rdata;
    logic               o_busy;
    logic [7:0]         o_err_count;
    logic [2:0]         o_state;

    gpu_wb_slave_if #(
        .ADDR_W(AW), .DATA_W(DW), .RSEL_W(4), .REGION_LSB(12),
        .N_REGION(NREG), .READ_LATENCY(RL), .WAIT_CYCLES(WC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wb(wb_bus),
        .o_we(o_we), .o_re(o_re), .o_addr(o_addr), .o_wdata(o_wdata),
        .o_wsel(o_wsel), .i_rdata(i_rdata), .o_busy(o_busy),
        .o_err_count(o_err_count), .o_state(o_state)
    );

    // ---------------- backing memories (environment) ----------------
    logic [31:0] env_mem [NREG][4] = '{default: '0};
    logic        pipe_v [RL] = '{default: 1'b0};
    logic [31:0] pipe_d [RL] = '{default: '0};
    int          pipe_r [RL] = '{default: 0};

    // Memories accept strobes and return read data exactly RL cycles after o_re;
    // outside that window the read bus carries noise.
    always @(posedge clk) begin
        logic [NREG*DW-1:0] rd_next;
        for (int r = 0; r < NREG; r++)
            if (o_we[r])
                for (int b = 0; b < 4; b++)
                    if (o_wsel[b]) env_mem[r][o_addr[3:2]][b*8 +: 8] = o_wdata[b*8 +: 8];
        for (int j = RL - 1; j > 0; j--) begin
            pipe_v[j] = pipe_v[j-1];
            pipe_d[j] = pipe_d[j-1];
            pipe_r[j] = pipe_r[j-1];
        end
        pipe_v[0] = 1'b0;
        pipe_d[0] = '0;
        pipe_r[0] = 0;
        for (int r = 0; r < NREG; r++)
            if (o_re[r]) begin
                pipe_v[0] = 1'b1;
                pipe_d[0] = env_mem[r][o_addr[3:2]];
                pipe_r[0] = r;
            end
        rd_next = {$urandom, $urandom, $urandom};
        if (pipe_v[RL-1]) rd_next[pipe_r[RL-1]*DW +: DW] = pipe_d[RL-1];
        i_rdata <= rd_next;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [NREG][4] = '{default: '0};
    logic [31:0] exp_q[$];
    logic [31:0] last_read = '0;
    int          exp_err_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (sel[b]) res[b*8 +: 8] = nw[b*8 +: 8];
        return res;
    endfunction

    // ---------------- driver ----------------
    int          ob_we_k, ob_we_n, ob_re_k, ob_re_n, ob_ack_k, ob_err_k, ob_both;
    logic [2:0]  ob_we_v, ob_re_v;
    logic [31:0] ob_dat;
    int unsigned ob_ack_abs, ob_re_abs;
    bit          ob_done;

    task automatic bus_idle();
        wb_bus.wb_cyc_i = 1'b0;
        wb_bus.wb_stb_i = 1'b0;
    endtask

    task automatic bus_req(input bit we, input logic [AW-1:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        wb_bus.wb_cyc_i = 1'b1;
        wb_bus.wb_stb_i = 1'b1;
        wb_bus.wb_we_i  = we;
        wb_bus.wb_adr_i = adr;
        wb_bus.wb_dat_i = dat;
        wb_bus.wb_sel_i = sel;
    endtask

    // One transfer; k counts cycles after the sampling edge T0 (k=1 is T0+1).
    task automatic xfer(input bit we, input logic [AW-1:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit hold);
        int k;
        @(negedge clk);
        bus_req(we, adr, dat, sel);
        @(posedge clk);
        k = 0;
        ob_we_k = 0; ob_we_n = 0; ob_re_k = 0; ob_re_n = 0;
        ob_ack_k = 0; ob_err_k = 0; ob_both = 0; ob_done = 1'b0;
        ob_we_v = '0; ob_re_v = '0; ob_dat = '0; ob_ack_abs = 0; ob_re_abs = 0;
        while (!ob_done && k < 40) begin
            @(negedge clk);
            k++;
            if (o_we != '0) begin
                if (ob_we_n == 0) begin ob_we_k = k; ob_we_v = o_we; end
                ob_we_n++;
            end
            if (o_re != '0) begin
                if (ob_re_n == 0) begin ob_re_k = k; ob_re_v = o_re; ob_re_abs = cyc_n; end
                ob_re_n++;
            end
            if (wb_bus.wb_ack_o && wb_bus.wb_err_o) ob_both = 1;
            if (wb_bus.wb_ack_o) begin
                ob_ack_k = k; ob_ack_abs = cyc_n; ob_dat = wb_bus.wb_dat_o; ob_done = 1'b1;
            end
            if (wb_bus.wb_err_o) begin
                ob_err_k = k; ob_done = 1'b1;
            end
        end
        if (!hold) bus_idle();
        check("xfer_timeout", 32'(ob_done), 32'd1);
    endtask

    // Issue a transfer and compare everything against the model's prediction.
    task automatic run_and_check(input bit we, input logic [AW-1:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input bit hold);
        int region, word;
        region = int'(adr[15:12]);
        word   = int'(adr[3:2]);
        if (region < NREG && !we) exp_q.push_back(ref_mem[region][word]);
        xfer(we, adr, dat, sel, hold);
        check("ack_err_both", 32'(ob_both), 32'd0);
        check("o_addr", 32'(o_addr), 32'(adr));
        check("o_wdata", o_wdata, dat);
        check("o_wsel", 32'(o_wsel), 32'(sel));
        if (region >= NREG) begin
            exp_err_cnt = (exp_err_cnt >= 255) ? 255 : exp_err_cnt + 1;
            check("err_cycle", 32'(ob_err_k), 32'd1);
            check("err_no_ack", 32'(ob_ack_k), 32'd0);
            check("err_no_strobe", 32'(ob_we_n + ob_re_n), 32'd0);
        end else if (we) begin
            ref_mem[region][word] = merge(ref_mem[region][word], dat, sel);
            check("wr_we_cycle", 32'(ob_we_k), 32'd1);
            check("wr_we_onehot", 32'(ob_we_v), 32'(1 << region));
            check("wr_we_width", 32'(ob_we_n), 32'd1);
            check("wr_no_re", 32'(ob_re_n), 32'd0);
            check("wr_ack_cycle", 32'(ob_ack_k), 32'(2 + WC));
            check("wr_dat_o_hold", wb_bus.wb_dat_o, last_read);
        end else begin
            check("rd_re_cycle", 32'(ob_re_k), 32'd1);
            check("rd_re_onehot", 32'(ob_re_v), 32'(1 << region));
            check("rd_re_width", 32'(ob_re_n), 32'd1);
            check("rd_no_we", 32'(ob_we_n), 32'd0);
            check("rd_ack_cycle", 32'(ob_ack_k), 32'(2 + RL));
            check("rd_data", ob_dat, exp_q.pop_front());
            last_read = ob_dat;
        end
        check("err_count", 32'(o_err_count), 32'(exp_err_cnt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned ack_abs;
        int          acks;
        logic [AW-1:0] adr;

        reset_n = 1'b0;
        wb_bus.wb_we_i  = 1'b0;
        wb_bus.wb_adr_i = '0;
        wb_bus.wb_dat_i = '0;
        wb_bus.wb_sel_i = '0;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(wb_bus.wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_bus.wb_err_o), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_strobes", 32'({o_we, o_re}), 32'd0);
        check("rst_dat_o", wb_bus.wb_dat_o, 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_err_count", 32'(o_err_count), 32'd0);
        reset_n = 1'b1;

        // Directed write to region 1, then write + read of region 2.
        run_and_check(1'b1, 27'h1000, 32'hDEADBEEF, 4'hF, 1'b0);
        run_and_check(1'b1, 27'h2004, 32'h12345678, 4'hF, 1'b0);
        run_and_check(1'b0, 27'h2004, 32'h0, 4'h0, 1'b0);
        check("dir_read_value", last_read, 32'h12345678);

        // Unmapped region: first error, then saturate the counter.
        run_and_check(1'b1, 27'h5000, 32'hA5A5A5A5, 4'hF, 1'b0);
        check("err_count_first", 32'(o_err_count), 32'd1);
        for (int i = 0; i < 299; i++)
            run_and_check(1'b1, 27'h5000, $urandom, 4'(i), 1'b0);
        check("err_count_sat", 32'(o_err_count), 32'd255);

        // Back-to-back write then read of region 0 with stb held across the ack.
        run_and_check(1'b1, 27'h000C, 32'hCAFEF00D, 4'hF, 1'b1);
        ack_abs = ob_ack_abs;
        run_and_check(1'b0, 27'h000C, 32'h0, 4'h0, 1'b0);
        check("b2b_re_spacing", ob_re_abs - ack_abs, 32'd2);
        check("b2b_read_value", last_read, 32'hCAFEF00D);

        // Master abort during the read wait.
        @(negedge clk);
        bus_req(1'b0, 27'h1000, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        check("abort_re", 32'(o_re), 32'b010);
        @(negedge clk);
        wb_bus.wb_cyc_i = 1'b0;
        acks = 0;
        @(negedge clk);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_dat_o", wb_bus.wb_dat_o, last_read);
        for (int i = 0; i < 4; i++) begin
            if (wb_bus.wb_ack_o || wb_bus.wb_err_o) acks++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(acks), 32'd0);
        bus_idle();

        // Randomized traffic across mapped and unmapped regions.
        for (int i = 0; i < 150; i++) begin
            adr = AW'($urandom);
            adr[15:12] = 4'($urandom_range(0, 4));
            run_and_check(1'($urandom_range(0, 1)), adr, $urandom,
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        bus_idle();

        // Reset during the write wait state.
        @(negedge clk);
        bus_req(1'b1, 27'h0008, 32'h0BADC0DE, 4'hF);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ack", 32'(wb_bus.wb_ack_o), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_dat_o", wb_bus.wb_dat_o, 32'd0);
        check("mid_rst_wdata", o_wdata, 32'd0);
        check("mid_rst_wsel_addr", 32'({o_wsel, o_addr}), 32'd0);
        check("mid_rst_err_count", 32'(o_err_count), 32'd0);
        ref_mem[0][2] = 32'h0BADC0DE;
        exp_err_cnt   = 0;
        last_read     = '0;
        reset_n = 1'b1;
        bus_idle();
        run_and_check(1'b1, 27'h1008, 32'h55AA33CC, 4'b0101, 1'b0);
        run_and_check(1'b0, 27'h1008, 32'h0, 4'h0, 1'b0);
        run_and_check(1'b0, 27'h0008, 32'h0, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
